// File: rtl/sprite_rom_slot_scheduler.sv
// Sprite ROM slot scheduler: 4-cycle pixel phase, packs row fetches
// into the two ROM ports and returns tagged strobes aligned to data.
module sprite_rom_slot_scheduler #(
  parameter int NUM_REQ = 6,
  parameter int ADDR_W  = 8,
  parameter int TAG_W   = 3
) (
  input  logic                      clk_100mhz,
  input  logic                      rst,
  input  logic                      line_sync,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [1:0]                phase,
  output logic [ADDR_W-1:0]         rom_addr_a,
  output logic [ADDR_W-1:0]         rom_addr_b,
  output logic                      rom_en_a,
  output logic                      rom_en_b,
  output logic                      ret_valid_a,
  output logic [TAG_W-1:0]          ret_tag_a,
  output logic                      ret_valid_b,
  output logic [TAG_W-1:0]          ret_tag_b,
  output logic                      pix_done,
  output logic [7:0]                drop_count
);

  logic [NUM_REQ-1:0] pending;
  logic [ADDR_W-1:0]  addr_q [NUM_REQ];
  logic [TAG_W-1:0]   tag_a_q;
  logic [TAG_W-1:0]   tag_b_q;

  logic               capture;
  logic               issue_ok;
  logic [NUM_REQ-1:0] src;
  logic [ADDR_W-1:0]  src_addr [NUM_REQ];
  logic               hit_a;
  logic               hit_b;
  logic [TAG_W-1:0]   idx_a;
  logic [TAG_W-1:0]   idx_b;
  logic [ADDR_W-1:0]  addr_a_n;
  logic [ADDR_W-1:0]  addr_b_n;
  logic [NUM_REQ-1:0] clr;
  logic [3:0]         left;
  logic [8:0]         drop_sum;
  logic [7:0]         drop_n;

  // The phase-3 decision picks straight from the inputs being
  // captured, so the first pair is on the ports during phase 0.
  assign capture  = (phase == 2'd3);
  assign issue_ok = (phase != 2'd2);

  // Candidate addresses: live inputs at capture, latched otherwise.
  always_comb begin
    src = capture ? req_valid : pending;
    for (int i = 0; i < NUM_REQ; i++) begin
      src_addr[i] = capture ? req_addr[i*ADDR_W +: ADDR_W]
                            : addr_q[i];
    end
  end

  // Lowest pending bit goes to port A, next-lowest to port B.
  always_comb begin
    hit_a    = 1'b0;
    hit_b    = 1'b0;
    idx_a    = '0;
    idx_b    = '0;
    addr_a_n = '0;
    addr_b_n = '0;
    clr      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (src[i]) begin
        if (!hit_a) begin
          hit_a    = 1'b1;
          idx_a    = TAG_W'(i);
          addr_a_n = src_addr[i];
          clr[i]   = 1'b1;
        end else if (!hit_b) begin
          hit_b    = 1'b1;
          idx_b    = TAG_W'(i);
          addr_b_n = src_addr[i];
          clr[i]   = 1'b1;
        end
      end
    end
  end

  // Requests left over at capture time are the ones being dropped.
  always_comb begin
    left = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      left = left + 4'(pending[i]);
    end
    drop_sum = {1'b0, drop_count} + 9'(left);
    drop_n   = drop_sum[8] ? 8'hFF : drop_sum[7:0];
  end

  // Per-requester address latch, loaded once per pixel.
  always_ff @(posedge clk_100mhz or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) addr_q[i] <= '0;
    end else if (capture && !line_sync) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        addr_q[i] <= req_addr[i*ADDR_W +: ADDR_W];
      end
    end
  end

  // Phase counter, pending set, port issue and return strobes.
  always_ff @(posedge clk_100mhz or posedge rst) begin
    if (rst) begin
      phase       <= 2'd0;
      pending     <= '0;
      rom_addr_a  <= '0;
      rom_addr_b  <= '0;
      rom_en_a    <= 1'b0;
      rom_en_b    <= 1'b0;
      tag_a_q     <= '0;
      tag_b_q     <= '0;
      ret_valid_a <= 1'b0;
      ret_valid_b <= 1'b0;
      ret_tag_a   <= '0;
      ret_tag_b   <= '0;
      pix_done    <= 1'b0;
      drop_count  <= 8'd0;
    end else begin
      ret_valid_a <= rom_en_a;
      ret_valid_b <= rom_en_b;
      ret_tag_a   <= tag_a_q;
      ret_tag_b   <= tag_b_q;
      if (line_sync) begin
        phase    <= 2'd0;
        pending  <= '0;
        rom_en_a <= 1'b0;
        rom_en_b <= 1'b0;
        pix_done <= 1'b0;
      end else begin
        phase    <= phase + 2'd1;
        pix_done <= (phase == 2'd2);
        rom_en_a <= issue_ok && hit_a;
        rom_en_b <= issue_ok && hit_b;
        if (issue_ok && hit_a) begin
          rom_addr_a <= addr_a_n;
          tag_a_q    <= idx_a;
        end
        if (issue_ok && hit_b) begin
          rom_addr_b <= addr_b_n;
          tag_b_q    <= idx_b;
        end
        if (capture) begin
          pending    <= req_valid & ~clr;
          drop_count <= drop_n;
        end else if (issue_ok) begin
          pending    <= pending & ~clr;
        end
      end
    end
  end

endmodule

// File: tb/tb_sprite_rom_slot_scheduler.sv
// Bench for sprite_rom_slot_scheduler: queue-based pixel model,
// directed scenarios plus randomized request/line_sync traffic.
module tb_sprite_rom_slot_scheduler;

  localparam int NR = 8;
  localparam int AW = 8;
  localparam int TW = 3;

  logic          clk_100mhz;
  logic          rst;
  logic          line_sync;
  logic [NR-1:0] req_valid;
  logic [NR*AW-1:0] req_addr;
  logic [1:0]    phase;
  logic [AW-1:0] rom_addr_a;
  logic [AW-1:0] rom_addr_b;
  logic          rom_en_a;
  logic          rom_en_b;
  logic          ret_valid_a;
  logic [TW-1:0] ret_tag_a;
  logic          ret_valid_b;
  logic [TW-1:0] ret_tag_b;
  logic          pix_done;
  logic [7:0]    drop_count;

  sprite_rom_slot_scheduler #(
    .NUM_REQ(NR), .ADDR_W(AW), .TAG_W(TW)
  ) dut (
    .clk_100mhz (clk_100mhz),
    .rst        (rst),
    .line_sync  (line_sync),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .phase      (phase),
    .rom_addr_a (rom_addr_a),
    .rom_addr_b (rom_addr_b),
    .rom_en_a   (rom_en_a),
    .rom_en_b   (rom_en_b),
    .ret_valid_a(ret_valid_a),
    .ret_tag_a  (ret_tag_a),
    .ret_valid_b(ret_valid_b),
    .ret_tag_b  (ret_tag_b),
    .pix_done   (pix_done),
    .drop_count (drop_count)
  );

  initial begin
    clk_100mhz = 1'b0;
    forever #5 clk_100mhz = ~clk_100mhz;
  end

  int n_chk;
  int n_bad;

  // model state: pixel phase and ordered list of still-unserved tags
  int       mph;
  int       mlist[$];
  int       maddr[NR];
  int       e_drop;
  bit       e_en_a, e_en_b, e_rv_a, e_rv_b, e_pd;
  int       e_addr_a, e_addr_b, e_tag_a, e_tag_b, e_rt_a, e_rt_b;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    mph = 0;
    mlist.delete();
    for (int i = 0; i < NR; i++) maddr[i] = 0;
    e_drop = 0;
    e_en_a = 0; e_en_b = 0; e_rv_a = 0; e_rv_b = 0; e_pd = 0;
    e_addr_a = 0; e_addr_b = 0;
    e_tag_a = 0; e_tag_b = 0; e_rt_a = 0; e_rt_b = 0;
  endtask

  task automatic model_step();
    int d;
    if (rst) begin
      model_reset();
      return;
    end
    e_rv_a = e_en_a; e_rt_a = e_tag_a;
    e_rv_b = e_en_b; e_rt_b = e_tag_b;
    if (line_sync) begin
      mph = 0;
      mlist.delete();
      e_en_a = 0; e_en_b = 0; e_pd = 0;
      return;
    end
    if (mph == 3) begin
      d = e_drop + mlist.size();
      e_drop = (d > 255) ? 255 : d;
      mlist.delete();
      for (int i = 0; i < NR; i++) begin
        if (req_valid[i]) begin
          mlist.push_back(i);
          maddr[i] = int'(req_addr[i*AW +: AW]);
        end
      end
    end
    // ports show pair k of the pixel during phase k (k = 0..2)
    if (mph != 2) begin
      e_en_a = (mlist.size() > 0);
      if (e_en_a) begin
        e_tag_a = mlist.pop_front();
        e_addr_a = maddr[e_tag_a];
      end
      e_en_b = (mlist.size() > 0);
      if (e_en_b) begin
        e_tag_b = mlist.pop_front();
        e_addr_b = maddr[e_tag_b];
      end
    end else begin
      e_en_a = 0; e_en_b = 0;
    end
    e_pd = (mph == 2);
    mph = (mph + 1) % 4;
  endtask

  task automatic compare();
    check("phase", 32'(phase), 32'(mph));
    check("en_a", 32'(rom_en_a), 32'(e_en_a));
    check("en_b", 32'(rom_en_b), 32'(e_en_b));
    check("addr_a", 32'(rom_addr_a), 32'(e_addr_a));
    check("addr_b", 32'(rom_addr_b), 32'(e_addr_b));
    check("rv_a", 32'(ret_valid_a), 32'(e_rv_a));
    check("rv_b", 32'(ret_valid_b), 32'(e_rv_b));
    if (e_rv_a) check("tag_a", 32'(ret_tag_a), 32'(e_rt_a));
    if (e_rv_b) check("tag_b", 32'(ret_tag_b), 32'(e_rt_b));
    check("pix_done", 32'(pix_done), 32'(e_pd));
    check("drop", 32'(drop_count), 32'(e_drop));
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk_100mhz);
    #1;
    compare();
  endtask

  task automatic set_addr_seq(input int base);
    for (int i = 0; i < NR; i++) req_addr[i*AW +: AW] = 8'(base + i);
  endtask

  initial begin
    n_chk = 0;
    n_bad = 0;
    rst = 1'b1;
    line_sync = 1'b0;
    req_valid = '0;
    req_addr = '0;
    model_reset();
    #3;
    compare();
    cycle();
    cycle();
    rst = 1'b0;

    // idle: phase rolls, pix_done each phase 3, no enables
    repeat (10) cycle();

    // all six requesters, addresses 0x10+i
    req_valid = 8'h3F;
    set_addr_seq(8'h10);
    repeat (8) cycle();
    req_valid = '0;
    repeat (4) cycle();

    // sparse: tags 2 and 5 share the phase-0 slot
    req_valid = 8'b0010_0100;
    repeat (8) cycle();
    req_valid = '0;
    repeat (4) cycle();

    // line_sync during phase 1 while tags 4,5 still pending
    req_valid = 8'h3F;
    repeat (4) cycle();
    for (int k = 0; k < 8 && mph != 1; k++) cycle();
    check("ls_phase1", 32'(phase), 32'd1);
    line_sync = 1'b1;
    cycle();
    line_sync = 1'b0;
    req_valid = '0;
    repeat (6) cycle();

    // randomized traffic
    repeat (400) begin
      req_valid = NR'($urandom);
      req_addr = {$urandom, $urandom};
      line_sync = ($urandom_range(0, 19) == 0);
      cycle();
    end
    line_sync = 1'b0;

    // async reset in phase 2 with fetches in flight
    req_valid = 8'hFF;
    set_addr_seq(8'h40);
    repeat (4) cycle();
    for (int k = 0; k < 8 && mph != 2; k++) cycle();
    check("rst_in_ph2", 32'(phase), 32'd2);
    rst = 1'b1;
    #1;
    model_reset();
    compare();
    cycle();
    rst = 1'b0;
    repeat (12) cycle();

    // eight requesters every pixel: two drops per pixel, saturates
    req_valid = 8'hFF;
    repeat (800) cycle();
    check("drop_sat", 32'(drop_count), 32'd255);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
